sprite_frame_scheduler: RTL and testbench

//   Per-frame erase/draw sequencer for up to NUM_SPRITES fixed-shape sprites, in the 160x120 VGA pipeline.
//   On each frame tick it erases every sprite at its previously drawn position, then redraws it at its new position.

---
 rtl/sprite_pkg.sv | 43 ++++
 rtl/sprite_shape_rom.sv | 33 +++
 rtl/sprite_frame_scheduler.sv | 276 +++++++++++++++++++++++++++
 tb/tb_sprite_frame_scheduler.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// sprite_pkg
//   Shared definitions for the sprite frame scheduler: FSM state encoding,
//   sprite shape size, per-pixel offset tables and default colours.
//   Optional feature macro: SPRITE_WING_ANIM_EN adds DY_ALT, the dy table
//   used for the second wing-flap phase.
package sprite_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LATCH,
    ST_SEL,
    ST_ERASE,
    ST_DRAW,
    ST_DONE
  } state_t;

  // Sprite shape: 13 pixels, offsets relative to the anchor.
  localparam int PIX_N = 13;
  localparam int PIX_W = 4;
  localparam int OFS_W = 4;

  localparam logic signed [OFS_W-1:0] DX [PIX_N] = '{
    4'sd0, 4'sd0, -4'sd1, -4'sd2, -4'sd3, -4'sd4, -4'sd5,
    -4'sd3, -4'sd3, -4'sd4, -4'sd4, -4'sd5, -4'sd5
  };

  localparam logic signed [OFS_W-1:0] DY [PIX_N] = '{
    4'sd0, 4'sd1, 4'sd0, 4'sd0, 4'sd0, 4'sd0, 4'sd0,
    4'sd1, -4'sd1, 4'sd2, -4'sd2, 4'sd3, -4'sd3
  };

`ifdef SPRITE_WING_ANIM_EN
  // Wing pixels 7..12 flap: their dy is mirrored in phase 1.
  localparam logic signed [OFS_W-1:0] DY_ALT [PIX_N] = '{
    4'sd0, 4'sd1, 4'sd0, 4'sd0, 4'sd0, 4'sd0, 4'sd0,
    -4'sd1, 4'sd1, -4'sd2, 4'sd2, -4'sd3, 4'sd3
  };
`endif

  localparam logic [2:0] DEF_FG_COLOUR = 3'b111;
  localparam logic [2:0] DEF_BG_COLOUR = 3'b000;

endpackage

// File: rtl/sprite_shape_rom.sv
// sprite_shape_rom
//   Combinational lookup of the signed (dx, dy) offset of one sprite pixel.
//   Ports:
//     i_pix    pixel index 0..PIX_N-1 (out-of-range indices return 0,0)
//     i_phase  wing phase (only with SPRITE_WING_ANIM_EN)
//     o_dx     signed x offset
//     o_dy     signed y offset
//   Optional feature macro: SPRITE_WING_ANIM_EN.
module sprite_shape_rom
  import sprite_pkg::*;
(
  input  logic [PIX_W-1:0]        i_pix,
`ifdef SPRITE_WING_ANIM_EN
  input  logic                    i_phase,
`endif
  output logic signed [OFS_W-1:0] o_dx,
  output logic signed [OFS_W-1:0] o_dy
);

  always_comb begin
    o_dx = '0;
    o_dy = '0;
    if (i_pix < PIX_W'(PIX_N)) begin
      o_dx = DX[i_pix];
`ifdef SPRITE_WING_ANIM_EN
      o_dy = i_phase ? DY_ALT[i_pix] : DY[i_pix];
`else
      o_dy = DY[i_pix];
`endif
    end
  end

endmodule

// File: rtl/sprite_frame_scheduler.sv
// sprite_frame_scheduler
//   Per-frame erase/draw sequencer for up to NUM_SPRITES fixed-shape sprites.
//   On each frame tick every sprite is erased at its previously drawn
//   position and redrawn at its new one; pixels stream out over valid/ready.
//   Ports:
//     i_clk, i_rst          clock, asynchronous active-high reset
//     i_frame_tick          1-cycle pulse starting a frame pass
//     i_sprite_en/x/y       per-sprite enable and packed anchor coordinates
//     o_pix_x/y/colour      registered pixel, o_pix_valid / i_pix_ready handshake
//     o_busy                pass in progress
//     o_frame_done          1-cycle pulse at end of pass
//     o_overrun             sticky: tick seen while busy
//   Optional feature macro: SPRITE_WING_ANIM_EN (two-phase wing animation).
module sprite_frame_scheduler
  import sprite_pkg::*;
#(
  parameter int NUM_SPRITES = 7,
  parameter int X_W         = 8,
  parameter int Y_W         = 7,
  parameter int COLOUR_W    = 3,
  parameter int SCREEN_W    = 160,
  parameter int SCREEN_H    = 120,
  parameter logic [COLOUR_W-1:0] FG_COLOUR = COLOUR_W'(DEF_FG_COLOUR),
  parameter logic [COLOUR_W-1:0] BG_COLOUR = COLOUR_W'(DEF_BG_COLOUR)
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_frame_tick,
  input  logic [NUM_SPRITES-1:0]     i_sprite_en,
  input  logic [NUM_SPRITES*X_W-1:0] i_sprite_x,
  input  logic [NUM_SPRITES*Y_W-1:0] i_sprite_y,
  output logic [X_W-1:0]             o_pix_x,
  output logic [Y_W-1:0]             o_pix_y,
  output logic [COLOUR_W-1:0]        o_pix_colour,
  output logic                       o_pix_valid,
  input  logic                       i_pix_ready,
  output logic                       o_busy,
  output logic                       o_frame_done,
  output logic                       o_overrun
);

  // idx must be able to hold NUM_SPRITES itself (the "all done" value).
  localparam int IDX_W = $clog2(NUM_SPRITES + 1);
  localparam int N_PAD = 1 << IDX_W;

  state_t               r_state;
  state_t               w_state_next;
  logic [IDX_W-1:0]     r_idx;
  logic [PIX_W-1:0]     r_pix;
  logic                 r_valid;
  logic [X_W-1:0]       r_pix_x;
  logic [Y_W-1:0]       r_pix_y;
  logic [COLOUR_W-1:0]  r_pix_colour;
  logic                 r_overrun;
  logic                 r_phase;

  // Per-sprite views padded to a power of two so r_idx can index them
  // directly, including the idx==NUM_SPRITES terminal value.
  logic                 w_pad_en        [N_PAD];
  logic                 w_pad_old_valid [N_PAD];
  logic [X_W-1:0]       w_pad_sh_x      [N_PAD];
  logic [Y_W-1:0]       w_pad_sh_y      [N_PAD];
  logic [X_W-1:0]       w_pad_old_x     [N_PAD];
  logic [Y_W-1:0]       w_pad_old_y     [N_PAD];
  logic                 w_pad_old_phase [N_PAD];

  logic                 w_idx_end;
  logic                 w_cur_en;
  logic                 w_cur_old_valid;
  logic                 w_slot;
  logic                 w_last;
  logic                 w_walk_end;
  logic                 w_old_clear;
  logic                 w_old_set;
  logic                 w_latch;

  logic [X_W-1:0]       w_base_x;
  logic [Y_W-1:0]       w_base_y;
  logic                 w_rom_phase;
  logic signed [OFS_W-1:0] w_dx;
  logic signed [OFS_W-1:0] w_dy;
  logic [X_W:0]         w_sum_x;
  logic [Y_W:0]         w_sum_y;
  logic                 w_clip;

  assign w_idx_end       = (r_idx == IDX_W'(NUM_SPRITES));
  assign w_cur_en        = w_pad_en[r_idx];
  assign w_cur_old_valid = w_pad_old_valid[r_idx];
  // The output register may take a new pixel when it is empty or draining.
  assign w_slot          = !r_valid || i_pix_ready;
  assign w_last          = (r_pix == PIX_W'(PIX_N - 1));
  assign w_walk_end      = (r_state == ST_ERASE || r_state == ST_DRAW) && w_slot && w_last;
  assign w_old_clear     = w_walk_end && (r_state == ST_ERASE) && !w_cur_en;
  assign w_old_set       = w_walk_end && (r_state == ST_DRAW);
  assign w_latch         = (r_state == ST_LATCH);

  // Shadow (this frame) and old (last drawn) registers per sprite.
  for (genvar gi = 0; gi < N_PAD; gi++) begin : g_sprite
    if (gi < NUM_SPRITES) begin : g_live
      logic           r_sh_en;
      logic [X_W-1:0] r_sh_x;
      logic [Y_W-1:0] r_sh_y;
      logic           r_old_valid;
      logic [X_W-1:0] r_old_x;
      logic [Y_W-1:0] r_old_y;
      logic           r_old_phase;

      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          r_sh_en     <= 1'b0;
          r_sh_x      <= '0;
          r_sh_y      <= '0;
          r_old_valid <= 1'b0;
          r_old_x     <= '0;
          r_old_y     <= '0;
          r_old_phase <= 1'b0;
        end else begin
          if (w_latch) begin
            r_sh_en <= i_sprite_en[gi];
            r_sh_x  <= i_sprite_x[gi*X_W +: X_W];
            r_sh_y  <= i_sprite_y[gi*Y_W +: Y_W];
          end
          if (r_idx == IDX_W'(gi)) begin
            if (w_old_clear) begin
              r_old_valid <= 1'b0;
            end
            if (w_old_set) begin
              r_old_valid <= 1'b1;
              r_old_x     <= r_sh_x;
              r_old_y     <= r_sh_y;
              r_old_phase <= r_phase;
            end
          end
        end
      end

      assign w_pad_en[gi]        = r_sh_en;
      assign w_pad_old_valid[gi] = r_old_valid;
      assign w_pad_sh_x[gi]      = r_sh_x;
      assign w_pad_sh_y[gi]      = r_sh_y;
      assign w_pad_old_x[gi]     = r_old_x;
      assign w_pad_old_y[gi]     = r_old_y;
      assign w_pad_old_phase[gi] = r_old_phase;
    end else begin : g_pad
      assign w_pad_en[gi]        = 1'b0;
      assign w_pad_old_valid[gi] = 1'b0;
      assign w_pad_sh_x[gi]      = '0;
      assign w_pad_sh_y[gi]      = '0;
      assign w_pad_old_x[gi]     = '0;
      assign w_pad_old_y[gi]     = '0;
      assign w_pad_old_phase[gi] = 1'b0;
    end
  end

  // Erase walks the stored position/phase, draw walks this frame's snapshot.
  always_comb begin
    w_base_x    = w_pad_sh_x[r_idx];
    w_base_y    = w_pad_sh_y[r_idx];
    w_rom_phase = r_phase;
    if (r_state == ST_ERASE) begin
      w_base_x    = w_pad_old_x[r_idx];
      w_base_y    = w_pad_old_y[r_idx];
      w_rom_phase = w_pad_old_phase[r_idx];
    end
  end

  sprite_shape_rom u_rom (
    .i_pix   (r_pix),
`ifdef SPRITE_WING_ANIM_EN
    .i_phase (w_rom_phase),
`endif
    .o_dx    (w_dx),
    .o_dy    (w_dy)
  );

  // One extra bit makes negative results visible in the MSB.
  assign w_sum_x = {1'b0, w_base_x} + {{(X_W + 1 - OFS_W){w_dx[OFS_W-1]}}, w_dx};
  assign w_sum_y = {1'b0, w_base_y} + {{(Y_W + 1 - OFS_W){w_dy[OFS_W-1]}}, w_dy};
  assign w_clip  = w_sum_x[X_W] || (w_sum_x >= (X_W + 1)'(SCREEN_W)) ||
                   w_sum_y[Y_W] || (w_sum_y >= (Y_W + 1)'(SCREEN_H));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (i_frame_tick) w_state_next = ST_LATCH;
      ST_LATCH: w_state_next = ST_SEL;
      ST_SEL: begin
        if (w_idx_end) begin
          // Hold off the done pulse until the last pixel has left.
          if (w_slot) w_state_next = ST_DONE;
        end else if (w_cur_old_valid) begin
          w_state_next = ST_ERASE;
        end else if (w_cur_en) begin
          w_state_next = ST_DRAW;
        end
      end
      ST_ERASE: if (w_walk_end) w_state_next = w_cur_en ? ST_DRAW : ST_SEL;
      ST_DRAW:  if (w_walk_end) w_state_next = ST_SEL;
      ST_DONE:  w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_idx        <= '0;
      r_pix        <= '0;
      r_valid      <= 1'b0;
      r_pix_x      <= '0;
      r_pix_y      <= '0;
      r_pix_colour <= '0;
      r_overrun    <= 1'b0;
      r_phase      <= 1'b0;
    end else begin
      if (i_frame_tick && (r_state != ST_IDLE)) begin
        r_overrun <= 1'b1;
      end
      if (r_valid && i_pix_ready) begin
        r_valid <= 1'b0;
      end
      case (r_state)
        ST_LATCH: begin
          r_idx <= '0;
          r_pix <= '0;
        end
        ST_SEL: begin
          if (!w_idx_end && !w_cur_old_valid && !w_cur_en) begin
            r_idx <= r_idx + 1'b1;
          end
        end
        ST_ERASE, ST_DRAW: begin
          if (w_slot) begin
            // A clipped pixel still consumes its slot, with valid low.
            r_valid <= !w_clip;
            if (!w_clip) begin
              r_pix_x      <= w_sum_x[X_W-1:0];
              r_pix_y      <= w_sum_y[Y_W-1:0];
              r_pix_colour <= (r_state == ST_ERASE) ? BG_COLOUR : FG_COLOUR;
            end
            if (w_last) begin
              r_pix <= '0;
              if ((r_state == ST_DRAW) || !w_cur_en) begin
                r_idx <= r_idx + 1'b1;
              end
            end else begin
              r_pix <= r_pix + 1'b1;
            end
          end
        end
        ST_DONE: begin
`ifdef SPRITE_WING_ANIM_EN
          r_phase <= ~r_phase;
`endif
        end
        default: ;
      endcase
    end
  end

  assign o_pix_x      = r_pix_x;
  assign o_pix_y      = r_pix_y;
  assign o_pix_colour = r_pix_colour;
  assign o_pix_valid  = r_valid;
  assign o_busy       = (r_state != ST_IDLE);
  assign o_frame_done = (r_state == ST_DONE);
  assign o_overrun    = r_overrun;

endmodule

// File: tb/tb_sprite_frame_scheduler.sv
// tb_sprite_frame_scheduler
//   Scoreboard bench for sprite_frame_scheduler (default build, static shape).
//   A small frame model pushes expected pixels; transfers are collected and
//   compared in each scenario task.
`timescale 1ns/1ps
module tb_sprite_frame_scheduler;

  localparam int N = 7;
  localparam logic [2:0] FG = 3'b111;
  localparam logic [2:0] BG = 3'b000;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           tick = 1'b0;
  logic [N-1:0]   s_en = '0;
  logic [N*8-1:0] s_x = '0;
  logic [N*7-1:0] s_y = '0;
  logic [7:0]     pix_x;
  logic [6:0]     pix_y;
  logic [2:0]     pix_c;
  logic           pix_valid;
  logic           pix_ready = 1'b1;
  logic           busy;
  logic           done;
  logic           overrun;

  always #5 clk = ~clk;

  sprite_frame_scheduler dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_frame_tick (tick),
    .i_sprite_en  (s_en),
    .i_sprite_x   (s_x),
    .i_sprite_y   (s_y),
    .o_pix_x      (pix_x),
    .o_pix_y      (pix_y),
    .o_pix_colour (pix_c),
    .o_pix_valid  (pix_valid),
    .i_pix_ready  (pix_ready),
    .o_busy       (busy),
    .o_frame_done (done),
    .o_overrun    (overrun)
  );

  int n_checks = 0;
  int n_fail   = 0;

  int tb_dx [13] = '{0, 0, -1, -2, -3, -4, -5, -3, -3, -4, -4, -5, -5};
  int tb_dy [13] = '{0, 1, 0, 0, 0, 0, 0, 1, -1, 2, -2, 3, -3};

  logic [N-1:0] m_en = '0;
  int  m_x [N];
  int  m_y [N];
  bit  m_old_valid [N];
  int  m_old_x [N];
  int  m_old_y [N];

  logic [17:0] exp_q [$];
  logic [17:0] rx_q  [$];
  int frame_cycles, frame_dones, stall_err, first_valid, timed_out;

  function automatic logic [17:0] pk(int x, int y, logic [2:0] c);
    return {8'(x), 7'(y), c};
  endfunction

  task automatic model_shape(int x, int y, logic [2:0] c);
    for (int p = 0; p < 13; p++) begin
      int px = x + tb_dx[p];
      int py = y + tb_dy[p];
      if (px >= 0 && px < 160 && py >= 0 && py < 120) exp_q.push_back(pk(px, py, c));
    end
  endtask

  task automatic model_frame();
    exp_q.delete();
    for (int i = 0; i < N; i++) begin
      if (m_old_valid[i]) model_shape(m_old_x[i], m_old_y[i], BG);
      if (m_en[i]) begin
        model_shape(m_x[i], m_y[i], FG);
        m_old_valid[i] = 1'b1;
        m_old_x[i] = m_x[i];
        m_old_y[i] = m_y[i];
      end else begin
        m_old_valid[i] = 1'b0;
      end
    end
  endtask

  task automatic apply_inputs();
    s_en = m_en;
    for (int i = 0; i < N; i++) begin
      s_x[i*8 +: 8] = 8'(m_x[i]);
      s_y[i*7 +: 7] = 7'(m_y[i]);
    end
  endtask

  // Pulse a tick and collect transfers until frame_done (bounded).
  task automatic run_frame(input bit toggle, input int extra_tick_it);
    logic [17:0] held;
    bit held_valid = 1'b0;
    rx_q.delete();
    frame_cycles = 0; frame_dones = 0; stall_err = 0; first_valid = 0; timed_out = 1;
    apply_inputs();
    @(negedge clk);
    tick = 1'b1;
    for (int it = 1; it <= 400; it++) begin
      @(negedge clk);
      tick = (it == extra_tick_it);
      if (held_valid && !(pix_valid === 1'b1 && {pix_x, pix_y, pix_c} === held)) stall_err++;
      if (pix_valid === 1'b1 && first_valid == 0) first_valid = it;
      pix_ready  = toggle ? ~pix_ready : 1'b1;
      held_valid = pix_valid && !pix_ready;
      held       = {pix_x, pix_y, pix_c};
      if (pix_valid && pix_ready) rx_q.push_back({pix_x, pix_y, pix_c});
      if (done === 1'b1) begin
        frame_dones++;
        frame_cycles = it;
        timed_out = 0;
        break;
      end
    end
    tick = 1'b0;
    pix_ready = 1'b1;
    $display("frame: %0d transfers, %0d cycles, expected %0d pixels", rx_q.size(), frame_cycles, exp_q.size());
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({pix_valid, busy, done, overrun, pix_x, pix_y, pix_c} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got=%h required=0", {pix_valid, busy, done, overrun, pix_x, pix_y, pix_c});
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle busy=%b required=0", busy); end
  endtask

  task automatic test_single_draw();
    logic [17:0] got, want;
    int n_bg = 0;
    for (int i = 0; i < N; i++) begin m_x[i] = 0; m_y[i] = 0; end
    m_en = 7'b0000001; m_x[0] = 20; m_y[0] = 50;
    model_frame();
    run_frame(1'b0, 0);
    n_checks++;
    if (timed_out != 0) begin n_fail++; $display("FAIL draw_timeout got=%0d required=0", timed_out); end
    n_checks++;
    if (first_valid != 4) begin n_fail++; $display("FAIL draw_latency got=%0d required=4", first_valid); end
    // LATCH, SEL(0), 13 DRAW slots, SEL(1..7), DONE
    n_checks++;
    if (frame_cycles != 23) begin n_fail++; $display("FAIL draw_cycles got=%0d required=23", frame_cycles); end
    n_checks++;
    if (rx_q.size() != 13) begin n_fail++; $display("FAIL draw_count got=%0d required=13", rx_q.size()); end
    if (rx_q.size() == 13) begin
      n_checks++;
      if (rx_q[0] !== pk(20, 50, FG)) begin n_fail++; $display("FAIL draw_first got=%h required=%h", rx_q[0], pk(20, 50, FG)); end
      n_checks++;
      if (rx_q[12] !== pk(15, 47, FG)) begin n_fail++; $display("FAIL draw_last got=%h required=%h", rx_q[12], pk(15, 47, FG)); end
    end
    foreach (rx_q[k]) if (rx_q[k][2:0] == BG) n_bg++;
    n_checks++;
    if (n_bg != 0) begin n_fail++; $display("FAIL draw_no_erase got=%0d required=0", n_bg); end
    while (rx_q.size() > 0 && exp_q.size() > 0) begin
      got = rx_q.pop_front(); want = exp_q.pop_front(); n_checks++;
      if (got !== want) begin n_fail++; $display("FAIL draw_pix got=%h required=%h", got, want); end
    end
  endtask

  task automatic test_move();
    logic [17:0] got, want;
    m_x[0] = 21;
    model_frame();
    run_frame(1'b0, 0);
    n_checks++;
    if (frame_dones != 1) begin n_fail++; $display("FAIL move_done got=%0d required=1", frame_dones); end
    n_checks++;
    if (rx_q.size() != 26) begin n_fail++; $display("FAIL move_count got=%0d required=26", rx_q.size()); end
    if (rx_q.size() == 26) begin
      n_checks++;
      if (rx_q[0] !== pk(20, 50, BG)) begin n_fail++; $display("FAIL move_erase_first got=%h required=%h", rx_q[0], pk(20, 50, BG)); end
      n_checks++;
      if (rx_q[13] !== pk(21, 50, FG)) begin n_fail++; $display("FAIL move_draw_first got=%h required=%h", rx_q[13], pk(21, 50, FG)); end
    end
    while (rx_q.size() > 0 && exp_q.size() > 0) begin
      got = rx_q.pop_front(); want = exp_q.pop_front(); n_checks++;
      if (got !== want) begin n_fail++; $display("FAIL move_pix got=%h required=%h", got, want); end
    end
  endtask

  task automatic test_clip();
    logic [17:0] got, want;
    int n_fg = 0;
    m_x[0] = 2; m_y[0] = 1;
    model_frame();
    run_frame(1'b0, 0);
    // Only offsets with dx >= -2 (pixels 0..3) stay on screen at x0=2.
    foreach (rx_q[k]) if (rx_q[k][2:0] == FG) n_fg++;
    n_checks++;
    if (n_fg != 4) begin n_fail++; $display("FAIL clip_fg_count got=%0d required=4", n_fg); end
    // Clipped slots still cost a cycle: same length as a full erase+draw.
    n_checks++;
    if (frame_cycles != 36) begin n_fail++; $display("FAIL clip_cycles got=%0d required=36", frame_cycles); end
    n_checks++;
    if (rx_q.size() != exp_q.size()) begin n_fail++; $display("FAIL clip_count got=%0d required=%0d", rx_q.size(), exp_q.size()); end
    while (rx_q.size() > 0 && exp_q.size() > 0) begin
      got = rx_q.pop_front(); want = exp_q.pop_front(); n_checks++;
      if (got !== want) begin n_fail++; $display("FAIL clip_pix got=%h required=%h", got, want); end
    end
  endtask

  task automatic test_backpressure();
    logic [17:0] got, want;
    m_x[0] = 40; m_y[0] = 60;
    model_frame();
    run_frame(1'b1, 0);
    n_checks++;
    if (stall_err != 0) begin n_fail++; $display("FAIL bp_stable got=%0d required=0", stall_err); end
    n_checks++;
    if (frame_dones != 1) begin n_fail++; $display("FAIL bp_done got=%0d required=1", frame_dones); end
    n_checks++;
    if (rx_q.size() != exp_q.size()) begin n_fail++; $display("FAIL bp_count got=%0d required=%0d", rx_q.size(), exp_q.size()); end
    while (rx_q.size() > 0 && exp_q.size() > 0) begin
      got = rx_q.pop_front(); want = exp_q.pop_front(); n_checks++;
      if (got !== want) begin n_fail++; $display("FAIL bp_pix got=%h required=%h", got, want); end
    end
  endtask

  task automatic test_disable();
    logic [17:0] got, want;
    int n_fg, n_bg;
    for (int pass = 0; pass < 3; pass++) begin
      m_en = (pass == 0) ? 7'b0001001 : 7'b0000001;
      m_x[3] = 80; m_y[3] = 30;
      model_frame();
      run_frame(1'b0, 0);
      n_fg = 0; n_bg = 0;
      foreach (rx_q[k]) if (rx_q[k][2:0] == FG) n_fg++; else n_bg++;
      n_checks++;
      if (pass == 1 && (n_fg != 13 || n_bg != 26)) begin
        n_fail++; $display("FAIL dis_split fg=%0d bg=%0d required fg=13 bg=26", n_fg, n_bg);
      end
      if (pass == 2 && rx_q.size() != 26) begin
        n_fail++; $display("FAIL dis_old_cleared got=%0d required=26", rx_q.size());
      end
      n_checks++;
      if (rx_q.size() != exp_q.size()) begin n_fail++; $display("FAIL dis_count got=%0d required=%0d", rx_q.size(), exp_q.size()); end
      while (rx_q.size() > 0 && exp_q.size() > 0) begin
        got = rx_q.pop_front(); want = exp_q.pop_front(); n_checks++;
        if (got !== want) begin n_fail++; $display("FAIL dis_pix got=%h required=%h", got, want); end
      end
    end
  endtask

  task automatic test_overrun_reset();
    logic [17:0] got, want;
    bit found = 1'b0;
    model_frame();
    run_frame(1'b0, 5);
    n_checks++;
    if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_set got=%b required=1", overrun); end
    n_checks++;
    if (rx_q.size() != exp_q.size() || frame_dones != 1) begin
      n_fail++; $display("FAIL ovr_ignored got=%0d/%0d required=%0d/1", rx_q.size(), frame_dones, exp_q.size());
    end
    while (rx_q.size() > 0 && exp_q.size() > 0) begin
      got = rx_q.pop_front(); want = exp_q.pop_front(); n_checks++;
      if (got !== want) begin n_fail++; $display("FAIL ovr_pix got=%h required=%h", got, want); end
    end
    repeat (4) @(negedge clk);
    n_checks++;
    if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_sticky got=%b required=1", overrun); end
    // Reset in the middle of an erase walk.
    apply_inputs();
    @(negedge clk); tick = 1'b1;
    @(negedge clk); tick = 1'b0;
    for (int it = 0; it < 50 && !found; it++) begin
      @(negedge clk);
      if (pix_valid === 1'b1 && pix_c === BG) found = 1'b1;
    end
    n_checks++;
    if (!found) begin n_fail++; $display("FAIL rst_erase_seen got=0 required=1"); end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (pix_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid valid=%b busy=%b required 0 0", pix_valid, busy);
    end
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < N; i++) m_old_valid[i] = 1'b0;
    n_checks++;
    if (overrun !== 1'b0) begin n_fail++; $display("FAIL rst_overrun got=%b required=0", overrun); end
    model_frame();
    run_frame(1'b0, 0);
    n_checks++;
    if (rx_q.size() != 13) begin n_fail++; $display("FAIL rst_no_erase got=%0d required=13", rx_q.size()); end
    while (rx_q.size() > 0 && exp_q.size() > 0) begin
      got = rx_q.pop_front(); want = exp_q.pop_front(); n_checks++;
      if (got !== want) begin n_fail++; $display("FAIL rst_pix got=%h required=%h", got, want); end
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      m_x[i] = 0; m_y[i] = 0; m_old_valid[i] = 1'b0; m_old_x[i] = 0; m_old_y[i] = 0;
    end
    test_reset();
    test_single_draw();
    test_move();
    test_clip();
    test_backpressure();
    test_disable();
    test_overrun_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
